// File: rtl/ic_capture_ctrl.sv
// rtl/ic_capture_ctrl.sv - input-capture controller: pin sync, edge/prescale select, timestamp FIFO, status
module ic_capture_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ins,
    input  logic [TW-1:0] t_val_bi_0,
    input  logic [TW-1:0] t_val_bi_1,
    input  logic          wr_i,
    input  logic [31:0]   wdata_i,
    input  logic          rd_i,
    output logic [31:0]   ICCON,
    output logic [31:0]   ICBUF,
    output logic          ICBNE,
    output logic          ICOV
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] ICM_ANY  = 3'b001;
    localparam logic [2:0] ICM_FALL = 3'b010;
    localparam logic [2:0] ICM_RISE = 3'b011;
    localparam logic [2:0] ICM_PS4  = 3'b100;
    localparam logic [2:0] ICM_PS16 = 3'b101;

    // Pin synchroniser and edge history
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Control register fields
    logic [2:0] icm_q, icm_d;
    logic       ictmr_q, ictmr_d;

    // Prescaler, FIFO storage and bookkeeping
    logic [3:0]    psc_q, psc_d;
    logic [TW-1:0] fifo_q [FIFO_DEPTH];
    logic [TW-1:0] fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          icov_q, icov_d;

    logic          rise;
    logic          fall;
    logic          cap_evt;
    logic          flush;
    logic          full;
    logic          pop;
    logic          push;
    logic [TW-1:0] tsel;

    // Only ICM and ICTMR are held; the remaining write bits have no storage
    logic unused_wdata;
    assign unused_wdata = ^{wdata_i[31:8], wdata_i[6:3]};

    // Edge decode, capture qualification and FIFO handshake terms
    always_comb begin
        rise    = s2_q & ~s3_q;
        fall    = ~s2_q & s3_q;
        cap_evt = 1'b0;
        unique case (icm_q)
            ICM_ANY:  cap_evt = rise | fall;
            ICM_FALL: cap_evt = fall;
            ICM_RISE: cap_evt = rise;
            ICM_PS4:  cap_evt = rise & (psc_q == 4'd3);
            ICM_PS16: cap_evt = rise & (psc_q == 4'd15);
            default:  cap_evt = 1'b0;
        endcase
        // A mode change restarts capture from a clean slate; it beats any same-cycle event
        flush = wr_i & (wdata_i[2:0] != icm_q);
        full  = (count_q == CW'(FIFO_DEPTH));
        pop   = rd_i & (count_q != '0);
        // A pop in the same cycle frees the slot the push needs
        push  = cap_evt & (~full | pop);
        tsel  = ictmr_q ? t_val_bi_1 : t_val_bi_0;
    end

    // Next-state for synchroniser, control fields, prescaler and FIFO
    always_comb begin
        s1_d     = ins;
        s2_d     = s1_q;
        s3_d     = s2_q;
        icm_d    = icm_q;
        ictmr_d  = ictmr_q;
        psc_d    = psc_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        icov_d   = icov_q;

        if (wr_i) begin
            icm_d   = wdata_i[2:0];
            ictmr_d = wdata_i[7];
        end

        if (rise && (icm_q == ICM_PS4 || icm_q == ICM_PS16)) begin
            if (icm_q == ICM_PS4 && psc_q == 4'd3) begin
                psc_d = 4'd0;
            end else begin
                psc_d = psc_q + 4'd1;
            end
        end

        if (flush) begin
            psc_d    = 4'd0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            icov_d   = 1'b0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = tsel;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            if (cap_evt && full && !pop) begin
                icov_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            icm_q    <= 3'b000;
            ictmr_q  <= 1'b0;
            psc_q    <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            icov_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            icm_q    <= icm_d;
            ictmr_q  <= ictmr_d;
            psc_q    <= psc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            icov_q   <= icov_d;
            fifo_q   <= fifo_d;
        end
    end

    // Bus-side status and readback
    always_comb begin
        ICBNE = (count_q != '0);
        ICOV  = icov_q;
        ICBUF = ICBNE ? {{(32-TW){1'b0}}, fifo_q[rd_ptr_q]} : 32'd0;
        ICCON = {24'd0, ictmr_q, 2'b00, icov_q, ICBNE, icm_q};
    end

endmodule

// File: doc/ic_capture_ctrl.md
# ic_capture_ctrl

Input-capture controller that sequences the timer capture datapath. It synchronises the external `ins` pin and detects the edge selected by a bus-programmed mode, including prescaled modes. On each qualifying edge it pushes the selected timer's count into a small capture FIFO, and it reports buffer-not-empty and overflow status to the bus side. It sits between the free-running timers (`t_val_bi_0`, `t_val_bi_1`) and the bus read/write strobes, and feeds the downstream period/frequency calculation.

## Interface
- `FIFO_DEPTH`, 4: capture FIFO entries; power of two, at least 2.
- `TW`, 16: timer value width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ins`  in  1  asynchronous capture pin.
- `t_val_bi_0`  in  TW  timer 0 count.
- `t_val_bi_1`  in  TW  timer 1 count.
- `wr_i`  in  1  ICCON write strobe; one cycle per write.
- `wdata_i`  in  32  ICCON write data.
- `rd_i`  in  1  pop strobe; one cycle per read of ICBUF.
- `ICCON`  out  32  control/status readback.
- `ICBUF`  out  32  `{(32-TW)'b0, head timestamp}`; all zero when the FIFO is empty.
- `ICBNE`  out  1  FIFO not empty.
- `ICOV`  out  1  sticky overflow flag.

## Operation
- ICCON fields:
  - [2:0] ICM, writable.
  - [7] ICTMR, writable: 0 selects `t_val_bi_0`, 1 selects `t_val_bi_1`.
  - [3] ICBNE, read-only.
  - [4] ICOV, read-only.
  - All other bits read 0.
- ICM encodings:
  - 000: off.
  - 001: every edge.
  - 010: every falling edge.
  - 011: every rising edge.
  - 100: every 4th rising edge.
  - 101: every 16th rising edge.
  - 110 and 111: treated as off.
- Input path: two-flop synchroniser (s1, s2), then history flop s3.
  - Rise = s2 & ~s3.
  - Fall = ~s2 & s3.
  - The synchroniser runs in every mode.
- Prescaler: 4-bit counter, active in modes 100 and 101 only.
  - Increments on each rise.
  - A capture event fires on the rise that takes the counter from 3 (mode 100) or 15 (mode 101) back to 0.
- Capture: on an event, push the selected timer value, sampled in the event cycle, into the FIFO.
  - If the FIFO is full and no pop occurs that cycle, drop the value and set ICOV.
- ICOV is sticky. It clears only on reset or on a flush.
  - While ICOV = 1, captures into a non-full FIFO are still accepted.
- Pop: `rd_i` with the FIFO non-empty advances the read pointer.
  - `rd_i` on an empty FIFO is ignored.
- Flush: a `wr_i` whose ICM differs from the current ICM empties the FIFO and clears ICOV and the prescaler.
  - A write with the same ICM updates ICTMR only; no flush.
- Pointers: log2(FIFO_DEPTH)-bit read/write pointers wrap modulo FIFO_DEPTH.
  - A count of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- Outputs:
  - ICBNE = (count != 0).
  - ICBUF is driven from the registered `fifo[rd_ptr]` when ICBNE = 1, else 0.

## Timing
- Reset values:
  - ICCON = 0 (ICM = off, ICTMR = 0).
  - ICBUF = 0, ICBNE = 0, ICOV = 0.
  - FIFO contents, pointers, count, prescaler = 0.
  - s1, s2, s3 = 0.
- Reset asserted mid-operation discards everything immediately, asynchronously. Recovery is on the first rising edge after `rst_n` rises.
- Capture latency, for `ins` changing before edge n:
  - s1 updates at edge n, s2 at n+1, s3 at n+2.
  - The event is detected in the cycle between n+1 and n+2; the push happens at n+2.
  - ICBNE and ICBUF are valid after edge n+2.
- Stored timestamp = the timer value present in the cycle before edge n+2.
- ICCON write takes effect at the edge where `wr_i` = 1.
  - An event in that same cycle is evaluated with the old mode.
  - If the write flushes, the flush wins and the event's push is dropped.
- Pop takes effect at the edge where `rd_i` = 1. The new head appears on ICBUF after that edge.
- Push and pop in the same cycle:
  - FIFO full: both occur, count unchanged, no overflow.
  - FIFO empty: push only.
- Throughput: one capture per cycle maximum. Mode 001 needs `ins` pulses at least 2 cycles wide to register both edges.

## Test plan
- Reset with ICM = 011: one `ins` rise while `t_val_bi_0` ramps +1 per cycle.
  - ICBNE rises 3 cycles after the pin change.
  - ICBUF equals the timer value of the cycle before the push.
- Mode 100, 8 rising edges.
  - Exactly 2 entries are captured, on the 4th and 8th rise.
  - Falling edges are ignored.
- Mode 011, 5 edges with no reads (depth 4).
  - ICOV = 1 and the FIFO holds the first 4 stamps.
  - 4 pops return them in order, then ICBNE = 0 and ICBUF = 0.
  - ICOV remains 1.
- FIFO full, `rd_i` in the same cycle as a capture.
  - Count stays 4, ICOV stays 0, the oldest entry is removed.
- Write ICM = 001 over a full, overflowed FIFO.
  - Next cycle ICBNE = 0, ICOV = 0, ICCON[2:0] = 001.
  - Then a 3-cycle pulse on `ins` yields 2 captures.
  - ICTMR = 1 selects `t_val_bi_1` values.
- Assert `rst_n` low asynchronously mid-prescale, with 2 entries queued.
  - All outputs are 0 immediately.
  - After release the prescaler restarts from 0.
